// File: rtl/mpadd_pkg.sv
// Shared types and helpers for the multi-precision limb-serial adder.
// Optional subtract support is enabled by defining MPADD_SUB_EN.
package mpadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mpadd_state_t;

  // Limb index width; at least one bit so K=1 still has a legal register.
  function automatic int idx_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/mpadd_seq_if.sv
// Operand/result handshake bundle for mpadd_seq.
// op_sub exists only when MPADD_SUB_EN is defined.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds in_valid and operands stable until accepted;
// the block holds out_valid, sum and cout stable until out_ready is seen.
interface mpadd_seq_if #(
  parameter int W = 8,
  parameter int K = 4
) ();
  import mpadd_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [W*K-1:0]   a;
  logic [W*K-1:0]   b;
  logic             cin;
`ifdef MPADD_SUB_EN
  logic             op_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [W*K-1:0]   sum;
  logic             cout;
  logic             busy;
  mpadd_state_t     dbg_state;

`ifdef MPADD_SUB_EN
  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, busy, dbg_state
  );
  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy, dbg_state
  );
`else
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy, dbg_state
  );
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy, dbg_state
  );
`endif

endinterface

// File: rtl/mpadd_seq_fa.sv
// N-bit ripple adder with carry in/out; the single shared limb adder.
module fulladderNbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] s_o,
  output logic         c_o
);

  // Full N+1-bit result so the carry out is never truncated.
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, c_i};

endmodule

// File: rtl/mpadd_seq.sv
// Limb-serial W*K-bit adder: one W-bit limb per cycle through a single adder,
// carry held in a flop between limbs. MPADD_SUB_EN adds A-B support (op_sub).
module mpadd_seq
  import mpadd_pkg::*;
#(
  parameter int W = 8,
  parameter int K = 4
) (
  input  logic        clk,
  input  logic        rst,
  mpadd_seq_if.slave  bus
);

  localparam int IW = idx_w(K);
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  mpadd_state_t    state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W*K-1:0]  a_q, a_d;
  logic [W*K-1:0]  b_q, b_d;
  logic [W*K-1:0]  sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
`ifdef MPADD_SUB_EN
  logic            sub_q, sub_d;
`endif

  logic [W-1:0]    limb_a;
  logic [W-1:0]    limb_b;
  logic [W-1:0]    limb_s;
  logic            limb_c;

  // Select the current limb; subtraction feeds the inverted B limb.
  always_comb begin
    limb_a = a_q[idx_q*W +: W];
`ifdef MPADD_SUB_EN
    limb_b = b_q[idx_q*W +: W] ^ {W{sub_q}};
`else
    limb_b = b_q[idx_q*W +: W];
`endif
  end

  fulladderNbit #(.N(W)) u_fa (
    .a_i (limb_a),
    .b_i (limb_b),
    .c_i (carry_q),
    .s_o (limb_s),
    .c_o (limb_c)
  );

  // Next-state and datapath register updates for IDLE -> RUN -> DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef MPADD_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d    = bus.a;
          b_d    = bus.b;
          idx_d  = '0;
          sum_d  = '0;
          cout_d = 1'b0;
`ifdef MPADD_SUB_EN
          sub_d   = bus.op_sub;
          // Two's complement: A + ~B + 1, so the external carry-in is unused.
          carry_d = bus.op_sub ? 1'b1 : bus.cin;
`else
          carry_d = bus.cin;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*W +: W] = limb_s;
        carry_d             = limb_c;
        if (idx_q == LAST_IDX) begin
          cout_d  = limb_c;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef MPADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef MPADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  // Handshake and status outputs decode straight from the state register.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.sum       = sum_q;
    bus.cout      = cout_q;
    bus.dbg_state = state_q;
  end

endmodule

// File: tb/tb_mpadd_seq.sv
// Directed plus random bench for mpadd_seq (W=8, K=4).
module tb_mpadd_seq;
  import mpadd_pkg::*;

  localparam int W = 8;
  localparam int K = 4;
  localparam int N = W * K;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [N:0] exp_q[$];

  mpadd_seq_if #(.W(W), .K(K)) bus ();

  mpadd_seq #(.W(W), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the whole add done at once in N+1-bit arithmetic.
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic cin, input logic sub);
    logic [N:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
    else     r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic cin, input logic sub);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef MPADD_SUB_EN
    bus.op_sub = sub;
`else
    if (sub) $display("note: subtract requested without MPADD_SUB_EN");
`endif
  endtask

  // One full transaction; hold = cycles the result is stalled with a stray in_valid.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic sub, input int hold);
    logic [N:0] exp;
    int lat;
    exp = model(a, b, cin, sub);
    drive_ops(a, b, cin, sub);
    bus.in_valid = 1'b1;
    check({tag, "_in_ready"}, bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, K);
    check({tag, "_sum"}, bus.sum, exp[N-1:0]);
    check({tag, "_cout"}, bus.cout, exp[N]);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      drive_ops(~a, a ^ b, ~cin, 1'b0);
      tick();
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_sum"}, bus.sum, exp[N-1:0]);
      check({tag, "_hold_cout"}, bus.cout, exp[N]);
      check({tag, "_hold_in_ready"}, bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"}, bus.out_valid, 0);
    check({tag, "_back_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    logic [N-1:0] pa[3];
    logic [N-1:0] pb[3];
    logic         pc[3];
    logic [N:0]   got_exp;
    int next_op, results, cycle, last_acc;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_ops('0, '0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_state", bus.dbg_state, IDLE);

    // Directed: full carry ripple, then carry-in
    run_op("t1", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 0);
    run_op("t2", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 0);

    // Result stalled for 5 cycles with a competing in_valid
    run_op("t3", 32'h8000_00FF, 32'h8000_0001, 1'b0, 1'b0, 5);

    // Reset two cycles after accept aborts the operation
    drive_ops(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("t4_busy", bus.busy, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_out_valid", bus.out_valid, 0);
    check("t4_sum", bus.sum, 0);
    check("t4_cout", bus.cout, 0);
    check("t4_in_ready", bus.in_ready, 1);
    check("t4_busy_clr", bus.busy, 0);
    run_op("t4_after", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, 0);

    // Back-to-back: in_valid and out_ready held high for three operations
    pa[0] = 32'h0000_00FF; pb[0] = 32'h0000_0001; pc[0] = 1'b0;
    pa[1] = $urandom;      pb[1] = $urandom;      pc[1] = 1'b1;
    pa[2] = $urandom;      pb[2] = $urandom;      pc[2] = 1'b0;
    bus.out_ready = 1'b1;
    next_op  = 0;
    results  = 0;
    cycle    = 0;
    last_acc = -1;
    while (results < 3 && cycle < 60) begin
      if (next_op < 3) begin
        bus.in_valid = 1'b1;
        drive_ops(pa[next_op], pb[next_op], pc[next_op], 1'b0);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(pa[next_op], pb[next_op], pc[next_op], 1'b0));
        if (last_acc >= 0) check("t5_spacing", cycle - last_acc, K + 2);
        last_acc = cycle;
        next_op++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() > 0) begin
          got_exp = exp_q.pop_front();
          check("t5_sum", bus.sum, got_exp[N-1:0]);
          check("t5_cout", bus.cout, got_exp[N]);
        end else begin
          check("t5_unexpected_result", 1, 0);
        end
        results++;
      end
      tick();
      cycle++;
    end
    check("t5_results", results, 3);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();

`ifdef MPADD_SUB_EN
    // Subtraction: borrow and no-borrow cases
    run_op("t6_neg", 32'd5, 32'd7, 1'b0, 1'b1, 0);
    run_op("t6_pos", 32'd7, 32'd5, 1'b0, 1'b1, 0);
`endif

    // Random operations with random stall lengths
    for (int i = 0; i < 12; i++) begin
      logic [N-1:0] ra, rb;
      logic rc, rs;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
`ifdef MPADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op("rand", ra, rb, rc, rs, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
